// File: rtl/dmem_access_ctrl_pkg.sv
// dmem_access_ctrl_pkg: size codes, FSM states and per-code byte-count helpers.
package dmem_access_ctrl_pkg;
    localparam logic [2:0] DM_WORD   = 3'b000;
    localparam logic [2:0] DM_HALF_U = 3'b001;
    localparam logic [2:0] DM_HALF_S = 3'b010;
    localparam logic [2:0] DM_BYTE_U = 3'b011;
    localparam logic [2:0] DM_BYTE_S = 3'b100;
    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;
    function automatic logic [1:0] last_of(input logic [2:0] c);
        return (c == DM_WORD) ? 2'd3 : (c == DM_HALF_U || c == DM_HALF_S) ? 2'd1 : 2'd0;
    endfunction
    function automatic logic is_legal(input logic [2:0] c);
        return c <= DM_BYTE_S;
    endfunction
endpackage

// File: rtl/dmem_access_ctrl_load_ext.sv
// dmem_access_ctrl_load_ext: sign/zero extension of an assembled load by size code.
module dmem_access_ctrl_load_ext
    import dmem_access_ctrl_pkg::*;
(
    input  logic [2:0]  i_num,
    input  logic [31:0] i_raw,
    output logic [31:0] o_ext
);
    assign o_ext = (i_num == DM_WORD)   ? i_raw :
                   (i_num == DM_HALF_S) ? {{16{i_raw[15]}}, i_raw[15:0]} :
                   (i_num == DM_HALF_U) ? {16'b0, i_raw[15:0]} :
                   (i_num == DM_BYTE_S) ? {{24{i_raw[7]}}, i_raw[7:0]} :
                                          {24'b0, i_raw[7:0]};
endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: sequences 32-bit CPU loads/stores onto a byte-wide RAM, one byte per cycle.
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
#(
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [2:0]        num,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    input  logic [7:0]        mem_rdata
);
    state_t            r_state, w_next;
    logic [2:0]        r_num;
    logic [ADDR_W-1:0] r_base, r_hold_addr;
    logic [31:0]       r_wdata, r_asm, r_rdata;
    logic [1:0]        r_cnt, r_last;
    logic              r_err;
    logic [7:0]        r_hold_wdata;
    logic [ADDR_W-1:0] w_addr;
    logic [7:0]        w_byte;
    logic [31:0]       w_asm, w_ext;
    logic              w_at_last;

    assign w_addr    = r_base + ADDR_W'(r_cnt);
    assign w_byte    = r_wdata[{r_cnt, 3'b000} +: 8];
    assign w_at_last = (r_cnt == r_last);

    always_comb begin
        w_asm = r_asm;
        w_asm[{r_cnt, 3'b000} +: 8] = mem_rdata;
    end

    dmem_access_ctrl_load_ext u_ext (
        .i_num (r_num),
        .i_raw (w_asm),
        .o_ext (w_ext)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = !req ? S_IDLE : !is_legal(num) ? S_DONE : we ? S_WR : S_RD;
            S_RD:    w_next = w_at_last ? S_DONE : S_RD;
            S_WR:    w_next = w_at_last ? S_DONE : S_WR;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_num        <= '0;
            r_base       <= '0;
            r_wdata      <= '0;
            r_cnt        <= '0;
            r_last       <= '0;
            r_err        <= 1'b0;
            r_asm        <= '0;
            r_rdata      <= '0;
            r_hold_addr  <= '0;
            r_hold_wdata <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && req) begin
                r_num   <= num;
                r_base  <= addr;
                r_wdata <= wdata;
                r_cnt   <= '0;
                r_last  <= last_of(num);
                r_err   <= !is_legal(num);
                r_asm   <= '0;
            end
            if (r_state == S_RD || r_state == S_WR) begin
                r_hold_addr <= w_addr;
                if (!w_at_last)
                    r_cnt <= r_cnt + 2'd1;
            end
            if (r_state == S_RD) begin
                r_asm <= w_asm;
                if (w_at_last)
                    r_rdata <= w_ext;
            end
            if (r_state == S_WR)
                r_hold_wdata <= w_byte;
        end
    end

    // RAM address/data follow the live byte pointer while active, otherwise hold the last value
    assign mem_addr  = (r_state == S_RD || r_state == S_WR) ? w_addr : r_hold_addr;
    assign mem_wdata = (r_state == S_WR) ? w_byte : r_hold_wdata;
    assign mem_we    = (r_state == S_WR);
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);
    assign err       = (r_state == S_DONE) && r_err;
    assign rdata     = r_rdata;
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: directed and random load/store checks against a byte-array memory model.
module tb_dmem_access_ctrl;
    logic        clk = 0, rst = 1, req = 0, we = 0;
    logic [2:0]  num = 0;
    logic [10:0] addr = 0;
    logic [31:0] wdata = 0;
    logic        busy, done, err, mem_we;
    logic [31:0] rdata;
    logic [10:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic [7:0]  ram [2048];
    logic [7:0]  ref_mem [2048];
    logic [31:0] exp_rd = 0;
    int          n_checks = 0, n_fail = 0, we_cnt = 0;

    dmem_access_ctrl #(.ADDR_W(11)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .num(num), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .err(err), .rdata(rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    assign mem_rdata = ram[mem_addr];
    always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;
    always @(negedge clk) if (mem_we) we_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_byte(input int a, input logic [7:0] v);
        ram[a] = v;
        ref_mem[a] = v;
    endtask

    task automatic do_op(input logic w, input logic [2:0] c, input logic [10:0] a, input logic [31:0] d);
        int n, cyc;
        logic [63:0] v;
        logic legal;
        legal = (c <= 3'd4);
        n = (c == 3'd0) ? 4 : (c <= 3'd2) ? 2 : 1;
        @(negedge clk);
        req = 1; we = w; num = c; addr = a; wdata = d; we_cnt = 0;
        @(posedge clk); #1;
        req = 0;
        cyc = 1;
        while (!done && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (legal && !w) begin
            v = 0;
            for (int i = 0; i < n; i++) v |= 64'(ref_mem[(int'(a) + i) % 2048]) << (8 * i);
            if ((c == 3'd2 || c == 3'd4) && v[8 * n - 1]) v |= ~((64'd1 << (8 * n)) - 1);
            exp_rd = v[31:0];
        end
        if (legal && w)
            for (int i = 0; i < n; i++) ref_mem[(int'(a) + i) % 2048] = d[8 * i +: 8];
        check("done_latency", cyc, legal ? n + 1 : 1);
        check("err", {31'b0, err}, {31'b0, !legal});
        check("busy_at_done", {31'b0, busy}, 1);
        check("rdata", rdata, exp_rd);
        @(posedge clk); #1;
        check("we_cycles", we_cnt, (legal && w) ? n : 0);
        check("idle_busy", {31'b0, busy}, 0);
        check("done_pulse", {31'b0, done}, 0);
    endtask

    initial begin
        int bad;
        for (int i = 0; i < 2048; i++) set_byte(i, 8'($urandom));
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_done", {31'b0, done}, 0);
        check("rst_err", {31'b0, err}, 0);
        check("rst_rdata", rdata, 0);
        check("rst_mem_we", {31'b0, mem_we}, 0);
        check("rst_mem_addr", {21'b0, mem_addr}, 0);
        check("rst_mem_wdata", {24'b0, mem_wdata}, 0);
        @(negedge clk) rst = 0;
        set_byte(11'h10, 8'h11); set_byte(11'h11, 8'h22); set_byte(11'h12, 8'h33); set_byte(11'h13, 8'h44);
        do_op(0, 3'd0, 11'h10, 0);
        check("t1_word", rdata, 32'h44332211);
        set_byte(11'h20, 8'h80); set_byte(11'h21, 8'hFF);
        do_op(0, 3'd2, 11'h20, 0);
        check("t2_half_s", rdata, 32'hFFFFFF80);
        do_op(0, 3'd1, 11'h20, 0);
        check("t2_half_u", rdata, 32'h0000FF80);
        set_byte(11'h30, 8'h9C);
        do_op(0, 3'd4, 11'h30, 0);
        check("t3_byte_s", rdata, 32'hFFFFFF9C);
        do_op(0, 3'd3, 11'h30, 0);
        check("t3_byte_u", rdata, 32'h0000009C);
        do_op(1, 3'd0, 11'h7FF, 32'hDEADBEEF);
        check("t4_7ff", {24'b0, ram[11'h7FF]}, 32'hEF);
        check("t4_000", {24'b0, ram[11'h000]}, 32'hBE);
        check("t4_001", {24'b0, ram[11'h001]}, 32'hAD);
        check("t4_002", {24'b0, ram[11'h002]}, 32'hDE);
        check("t4_rdata_kept", rdata, 32'h0000009C);
        set_byte(11'h42, 8'h5A);
        do_op(1, 3'd1, 11'h40, 32'h1234ABCD);
        check("t5_40", {24'b0, ram[11'h40]}, 32'hCD);
        check("t5_41", {24'b0, ram[11'h41]}, 32'hAB);
        check("t5_42", {24'b0, ram[11'h42]}, 32'h5A);
        do_op(1, 3'd7, 11'h50, 32'hFFFFFFFF);
        do_op(0, 3'd0, 11'h7FE, 0);
        @(negedge clk);
        req = 1; we = 0; num = 3'd0; addr = 11'h10;
        @(posedge clk); #1;
        req = 0;
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        exp_rd = 0;
        check("t6_busy", {31'b0, busy}, 0);
        check("t6_done", {31'b0, done}, 0);
        check("t6_rdata", rdata, 0);
        do_op(0, 3'd0, 11'h10, 0);
        check("t6_rereq", rdata, 32'h44332211);
        for (int k = 0; k < 60; k++)
            do_op(1'($urandom), 3'($urandom), 11'($urandom), $urandom);
        bad = 0;
        for (int i = 0; i < 2048; i++) if (ram[i] !== ref_mem[i]) bad++;
        check("ram_final", bad, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
